// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate datapath self-test sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [2:0]  MODE_AND  = 3'b100;
    localparam logic [2:0]  MODE_OR   = 3'b010;
    localparam logic [2:0]  MODE_XOR  = 3'b001;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // One MISR step: shift left, fold in the polynomial on carry-out, xor the sample into bit 0.
    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {15'b0, d};
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_misr16.sv
// 16-bit signature register; clr reseeds, en folds in one sample.
module misr16
    import gate_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = misr_next(sig_q, din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps every operand vector under AND/OR/XOR modes,
// samples the datapath output and accumulates per-mode ones-counts and a MISR.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned NPAIR  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 e,
    output logic [2*NPAIR-1:0]   dp_in,
    output logic [2:0]           dp_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*NPAIR:0]     cnt_and,
    output logic [2*NPAIR:0]     cnt_or,
    output logic [2*NPAIR:0]     cnt_xor,
    output logic [15:0]          sig
);

    localparam int unsigned W   = 2 * NPAIR;
    localparam int unsigned CW  = W + 1;
    localparam int unsigned SCW = 4;

    state_e         state_q, state_d;
    logic [W-1:0]   vec_q, vec_d;
    logic [2:0]     mode_q, mode_d;
    logic [SCW-1:0] set_q, set_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [CW-1:0]  cnt_and_q, cnt_and_d;
    logic [CW-1:0]  cnt_or_q, cnt_or_d;
    logic [CW-1:0]  cnt_xor_q, cnt_xor_d;
    logic           misr_clr;
    logic           misr_en;

    // Next-state, counters and stimulus; vec_q/mode_q drive the datapath directly.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        mode_d    = mode_q;
        set_d     = set_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_and_d = cnt_and_q;
        cnt_or_d  = cnt_or_q;
        cnt_xor_d = cnt_xor_q;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_SETTLE;
                    busy_d    = 1'b1;
                    vec_d     = '0;
                    mode_d    = MODE_AND;
                    set_d     = '0;
                    cnt_and_d = '0;
                    cnt_or_d  = '0;
                    cnt_xor_d = '0;
                    misr_clr  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (set_q == SCW'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                    set_d   = '0;
                end else begin
                    set_d = set_q + SCW'(1);
                end
            end
            ST_SAMPLE: begin
                misr_en = 1'b1;
                case (mode_q)
                    MODE_AND: cnt_and_d = cnt_and_q + CW'(e);
                    MODE_OR:  cnt_or_d  = cnt_or_q  + CW'(e);
                    MODE_XOR: cnt_xor_d = cnt_xor_q + CW'(e);
                    default:  ;
                endcase
                vec_d   = vec_q + W'(1);
                state_d = ST_SETTLE;
                if (vec_q == {W{1'b1}}) begin
                    if (mode_q == MODE_XOR) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mode_d  = '0;
                    end else begin
                        mode_d = mode_q >> 1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards the in-flight sample and freezes partial results.
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            vec_d     = '0;
            mode_d    = '0;
            set_d     = '0;
            cnt_and_d = cnt_and_q;
            cnt_or_d  = cnt_or_q;
            cnt_xor_d = cnt_xor_q;
            misr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            mode_q    <= '0;
            set_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_and_q <= '0;
            cnt_or_q  <= '0;
            cnt_xor_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            mode_q    <= mode_d;
            set_q     <= set_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_and_q <= cnt_and_d;
            cnt_or_q  <= cnt_or_d;
            cnt_xor_q <= cnt_xor_d;
        end
    end

    misr16 u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din (e),
        .sig (sig)
    );

    assign dp_in   = vec_q;
    assign dp_mode = mode_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cnt_and = cnt_and_q;
    assign cnt_or  = cnt_or_q;
    assign cnt_xor = cnt_xor_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance with SETTLE=2, one with SETTLE=1.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] emode;
    logic       sel;

    logic       ea, eb;
    logic [7:0] dpa, dpb;
    logic [2:0] ma, mb;
    logic       busya, busyb, donea, doneb;
    logic [8:0] caa, cao, cax, cba, cbo, cbx;
    logic [15:0] siga, sigb;

    logic [7:0]  o_dp;
    logic [2:0]  o_mode;
    logic        o_busy, o_done;
    logic [8:0]  o_ca, o_co, o_cx;
    logic [15:0] o_sig;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Datapath stand-in: 0 all-ones, 1 AND-mode & operands FF, 2 operand LSB, 3 zero.
    function automatic logic emodel(input logic [1:0] m, input logic [2:0] md, input logic [7:0] d);
        case (m)
            2'd0:    return 1'b1;
            2'd1:    return md[2] & (d == 8'hFF);
            2'd2:    return d[0];
            default: return 1'b0;
        endcase
    endfunction

    assign ea = emodel(emode, ma, dpa);
    assign eb = emodel(emode, mb, dpb);

    gate_sweep_ctrl #(.NPAIR(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .e(ea),
        .dp_in(dpa), .dp_mode(ma), .busy(busya), .done(donea),
        .cnt_and(caa), .cnt_or(cao), .cnt_xor(cax), .sig(siga)
    );

    gate_sweep_ctrl #(.NPAIR(4), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .e(eb),
        .dp_in(dpb), .dp_mode(mb), .busy(busyb), .done(doneb),
        .cnt_and(cba), .cnt_or(cbo), .cnt_xor(cbx), .sig(sigb)
    );

    always_comb begin
        o_dp   = sel ? dpb   : dpa;
        o_mode = sel ? mb    : ma;
        o_busy = sel ? busyb : busya;
        o_done = sel ? doneb : donea;
        o_ca   = sel ? cba   : caa;
        o_co   = sel ? cbo   : cao;
        o_cx   = sel ? cbx   : cax;
        o_sig  = sel ? sigb  : siga;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic d);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        n[0] = n[0] ^ d;
        return n;
    endfunction

    function automatic logic [15:0] ref_sig(input logic [1:0] m);
        logic [15:0] s;
        logic [2:0]  md;
        logic [7:0]  v;
        s = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            md = 3'b100 >> k;
            for (int i = 0; i < 256; i++) begin
                v = 8'(i);
                s = ref_step(s, emodel(m, md, v));
            end
        end
        return s;
    endfunction

    // Called in cycle T+1; returns done cycle offset, pulse count, mode order and bad hold runs.
    task automatic run_done(input int bound, input int extra_start, input int hold,
                            output int done_at, output int npulse,
                            output logic [8:0] seq, output int bad);
        logic [7:0] pdp;
        logic [2:0] pm, lastm;
        int         len;
        bit         inrun;
        done_at = 0; npulse = 0; seq = '0; bad = 0;
        len = 0; inrun = 0; pdp = '0; pm = '0; lastm = '0;
        for (int cyc = 1; cyc <= bound; cyc++) begin
            if (o_done) begin
                npulse++;
                if (done_at == 0) done_at = cyc;
            end
            if (o_mode != 3'b000 && o_mode != lastm) begin
                seq   = {seq[5:0], o_mode};
                lastm = o_mode;
            end
            if (o_busy) begin
                if (inrun && o_dp == pdp && o_mode == pm) begin
                    len++;
                end else begin
                    if (inrun && len != hold) bad++;
                    inrun = 1;
                    len   = 1;
                end
                pdp = o_dp;
                pm  = o_mode;
            end else if (inrun) begin
                if (len != hold) bad++;
                inrun = 0;
            end
            if (done_at != 0 && cyc >= done_at + 4) break;
            start = (cyc == extra_start);
            tick();
            start = 1'b0;
        end
    endtask

    int         done_at, npulse, bad, ndone;
    logic [8:0] seq;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; emode = 2'd0; sel = 1'b0;
        #1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset/idle state
        repeat (10) tick();
        chk("rst_mode", 32'(o_mode), 32'h0);
        chk("rst_dp",   32'(o_dp),   32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_sig",  32'(o_sig),  32'hFFFF);
        chk("rst_cnt",  32'({o_ca, o_co, o_cx}), 32'h0);

        // All-ones datapath, SETTLE=2
        emode = 2'd0; sel = 1'b0;
        pulse_start();
        chk("t2_busy1", 32'(o_busy), 32'h1);
        chk("t2_mode1", 32'(o_mode), 32'(3'b100));
        run_done(3000, 0, 3, done_at, npulse, seq, bad);
        chk("t2_done_at", 32'(done_at), 32'd2305);
        chk("t2_npulse",  32'(npulse),  32'd1);
        chk("t2_seq",     32'(seq),     32'(9'b100_010_001));
        chk("t2_hold",    32'(bad),     32'd0);
        chk("t2_and",     32'(o_ca),    32'd256);
        chk("t2_or",      32'(o_co),    32'd256);
        chk("t2_xor",     32'(o_cx),    32'd256);
        chk("t2_sig",     32'(o_sig),   32'(ref_sig(2'd0)));
        chk("t2_mode_end", 32'(o_mode), 32'h0);
        chk("t2_busy_end", 32'(o_busy), 32'h0);

        // Single hit in AND mode at operands FF
        emode = 2'd1;
        pulse_start();
        run_done(3000, 0, 3, done_at, npulse, seq, bad);
        chk("t3_done_at", 32'(done_at), 32'd2305);
        chk("t3_and", 32'(o_ca),  32'd1);
        chk("t3_or",  32'(o_co),  32'd0);
        chk("t3_xor", 32'(o_cx),  32'd0);
        chk("t3_sig", 32'(o_sig), 32'(ref_sig(2'd1)));

        // Operand LSB, SETTLE=1 instance
        emode = 2'd2; sel = 1'b1;
        pulse_start();
        run_done(3000, 0, 2, done_at, npulse, seq, bad);
        chk("t4_done_at", 32'(done_at), 32'd1537);
        chk("t4_npulse",  32'(npulse),  32'd1);
        chk("t4_hold",    32'(bad),     32'd0);
        chk("t4_and", 32'(o_ca),  32'd128);
        chk("t4_or",  32'(o_co),  32'd128);
        chk("t4_xor", 32'(o_cx),  32'd128);
        chk("t4_sig", 32'(o_sig), 32'(ref_sig(2'd2)));
        repeat (800) tick();
        sel = 1'b0;
        chk("t4_a_idle", 32'(o_busy), 32'h0);

        // Abort at T+700, then restart
        emode = 2'd0;
        pulse_start();
        repeat (699) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy",  32'(o_busy), 32'h0);
        chk("t5_mode",  32'(o_mode), 32'h0);
        chk("t5_dp",    32'(o_dp),   32'h0);
        chk("t5_and",   32'(o_ca),   32'd233);
        chk("t5_or",    32'(o_co),   32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_done) ndone++;
            tick();
        end
        chk("t5_nodone", 32'(ndone), 32'd0);
        chk("t5_held",   32'(o_ca),  32'd233);
        pulse_start();
        chk("t5_clr_cnt", 32'(o_ca),  32'd0);
        chk("t5_clr_sig", 32'(o_sig), 32'hFFFF);
        run_done(3000, 0, 3, done_at, npulse, seq, bad);
        chk("t5_done_at", 32'(done_at), 32'd2305);
        chk("t5_and2",    32'(o_ca),    32'd256);

        // Start while busy is ignored
        pulse_start();
        run_done(3000, 100, 3, done_at, npulse, seq, bad);
        chk("t6_busy_start_at", 32'(done_at), 32'd2305);
        chk("t6_busy_npulse",   32'(npulse),  32'd1);
        repeat (5) tick();

        // Start together with abort in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t6_sa_busy", 32'(o_busy), 32'h0);
        chk("t6_sa_mode", 32'(o_mode), 32'h0);
        repeat (5) tick();
        chk("t6_sa_busy2", 32'(o_busy), 32'h0);

        // Reset at T+50
        pulse_start();
        repeat (49) tick();
        chk("t6_pre_rst_and", 32'(o_ca), 32'd16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_busy", 32'(o_busy), 32'h0);
        chk("t6_rst_mode", 32'(o_mode), 32'h0);
        chk("t6_rst_dp",   32'(o_dp),   32'h0);
        chk("t6_rst_and",  32'(o_ca),   32'd0);
        chk("t6_rst_sig",  32'(o_sig),  32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
